// File: rtl/cpu_trace_unit_pkg.sv
// cpu_trace_unit_pkg: source ids, entry field layout and priority helper for the trace unit
package cpu_trace_unit_pkg;
  localparam int TRC_NUM_SRC = 8;
  localparam logic [3:0] TRC_SRC_PC = 4'd0;
  localparam logic [3:0] TRC_SRC_R0 = 4'd1;
  localparam logic [3:0] TRC_SRC_R1 = 4'd2;
  localparam logic [3:0] TRC_SRC_R2 = 4'd3;
  localparam logic [3:0] TRC_SRC_R3 = 4'd4;
  localparam logic [3:0] TRC_SRC_R4 = 4'd5;
  localparam logic [3:0] TRC_SRC_R5 = 4'd6;
  localparam logic [3:0] TRC_SRC_R6 = 4'd7;
  localparam int TRC_VALUE_LSB = 0;
  localparam int TRC_VALUE_W = 32;
  localparam int TRC_SRC_LSB = 32;
  localparam int TRC_SRC_W = 4;
  localparam int TRC_STAMP_LSB = 36;
  function automatic logic [2:0] trc_first_set(input logic [7:0] v);
    trc_first_set = '0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) trc_first_set = i[2:0];
  endfunction
endpackage

// File: rtl/cpu_trace_unit_if.sv
// cpu_trace_unit_if: valid/ready trace entry stream
interface cpu_trace_unit_if #(parameter int CYCLE_W = 16);
  logic [CYCLE_W+35:0] data;
  logic valid;
  logic ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/cpu_trace_unit_fifo.sv
// trace_fifo: synchronous FIFO with valid/ready pop, flush and occupancy count
module trace_fifo #(
  parameter int WIDTH = 52,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic valid,
  output logic full,
  output logic [AW:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_pop, do_push;
  always_comb begin
    valid = count != '0;
    full = count == (AW+1)'(DEPTH);
    do_pop = pop && valid;
    do_push = push && (!full || do_pop);
    dout = valid ? mem[rd] : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + AW'(do_pop);
      wr <= wr + AW'(do_push);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/cpu_trace_unit.sv
// cpu_trace_unit: detects changes on CPU PC/registers and streams stamped trace entries
module cpu_trace_unit import cpu_trace_unit_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int CYCLE_W = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] reg0_in,
  input  logic [31:0] reg1_in,
  input  logic [31:0] reg2_in,
  input  logic [31:0] reg3_in,
  input  logic [31:0] reg4_in,
  input  logic [31:0] reg5_in,
  input  logic [31:0] reg6_in,
  cpu_trace_unit_if.master trace,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0] drop_count
);
  logic [31:0] src_val [TRC_NUM_SRC];
  logic [31:0] shadow [TRC_NUM_SRC];
  logic [TRC_NUM_SRC-1:0] pending, changed, clr_mask, dropped;
  logic [CYCLE_W-1:0] cycle;
  logic [2:0] sel;
  logic [3:0] drop_inc;
  logic [16:0] drop_sum;
  logic full, pop, push;
  always_comb begin
    src_val = '{pc_in, reg0_in, reg1_in, reg2_in, reg3_in, reg4_in, reg5_in, reg6_in};
    for (int i = 0; i < TRC_NUM_SRC; i++) changed[i] = enable && src_val[i] != shadow[i];
    pop = trace.valid && trace.ready;
    sel = trc_first_set(pending);
    push = enable && |pending && (!full || pop);
    clr_mask = push ? 8'd1 << sel : '0;
    // a source re-changing in the cycle its entry is pushed re-arms rather than coalesces
    dropped = changed & pending & ~clr_mask;
    drop_inc = '0;
    for (int i = 0; i < TRC_NUM_SRC; i++) drop_inc = drop_inc + 4'(dropped[i]);
    drop_sum = {1'b0, drop_count} + 17'(drop_inc);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending <= '0;
      cycle <= '0;
      drop_count <= '0;
      shadow <= '{default: '0};
    end else if (clear) begin
      pending <= '0;
      cycle <= '0;
      drop_count <= '0;
      shadow <= src_val;
    end else if (enable) begin
      pending <= (pending & ~clr_mask) | changed;
      cycle <= cycle + 1'b1;
      drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];
      shadow <= src_val;
    end
  trace_fifo #(.WIDTH(CYCLE_W + 36), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(reset_n),
    .flush(clear),
    .push(push),
    .din({cycle, 1'b0, sel, shadow[sel]}),
    .pop(trace.ready),
    .dout(trace.data),
    .valid(trace.valid),
    .full(full),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_cpu_trace_unit.sv
// tb_cpu_trace_unit: directed scenarios for cpu_trace_unit with hand-computed entries
module tb_cpu_trace_unit;
  import cpu_trace_unit_pkg::*;
  localparam int DEPTH = 16;
  localparam int CYCLE_W = 16;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic [31:0] pc = '0, r0 = '0, r1 = '0, r2 = '0, r3 = '0, r4 = '0, r5 = '0, r6 = '0;
  logic [4:0] fifo_count;
  logic [15:0] drop_count;
  logic [31:0] val;
  logic [3:0] src;
  int checks = 0;
  int errors = 0;
  cpu_trace_unit_if #(.CYCLE_W(CYCLE_W)) trc();
  cpu_trace_unit #(.DEPTH(DEPTH), .CYCLE_W(CYCLE_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .pc_in(pc), .reg0_in(r0), .reg1_in(r1), .reg2_in(r2), .reg3_in(r3),
    .reg4_in(r4), .reg5_in(r5), .reg6_in(r6),
    .trace(trc), .fifo_count(fifo_count), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  assign val = trc.data[31:0];
  assign src = trc.data[35:32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    trc.ready = 1'b0;
    tick();
    tick();
    checks++; if (trc.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", trc.valid); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
    checks++; if (trc.data !== 52'd0) begin errors++; $display("FAIL reset_data got %h exp 0", trc.data); end
  endtask

  task automatic test_single();
    reset_n = 1'b1;
    enable = 1'b1;
    trc.ready = 1'b1;
    tick(); tick(); tick();
    pc = 32'h4;
    tick();
    checks++; if (trc.valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b exp 0", trc.valid); end
    tick();
    checks++; if (trc.valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", trc.valid); end
    checks++; if (trc.data !== {16'd4, 4'd0, 32'h4}) begin errors++; $display("FAIL single_data got %h exp %h", trc.data, {16'd4, 4'd0, 32'h4}); end
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count got %0d exp 1", fifo_count); end
    tick();
    checks++; if (trc.valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %0b exp 0", trc.valid); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL single_count_end got %0d exp 0", fifo_count); end
  endtask

  task automatic test_multi();
    logic [3:0] es [3];
    logic [31:0] ev [3];
    logic [51:0] exp_d;
    es = '{TRC_SRC_PC, TRC_SRC_R0, TRC_SRC_R3};
    ev = '{32'd8, 32'd5, 32'd9};
    pc = 32'd8; r0 = 32'd5; r3 = 32'd9;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_d = {16'(7 + k), es[k], ev[k]};
      checks++; if (trc.valid !== 1'b1 || trc.data !== exp_d) begin errors++; $display("FAIL multi_entry%0d got v=%0b %h exp %h", k, trc.valid, trc.data, exp_d); end
    end
    tick();
    checks++; if (trc.valid !== 1'b0) begin errors++; $display("FAIL multi_end_valid got %0b exp 0", trc.valid); end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    r0 = 32'd6;
    tick(); tick(); tick();
    checks++; if (trc.valid !== 1'b0 || fifo_count !== 5'd0) begin errors++; $display("FAIL enable_off got v=%0b cnt=%0d exp 0/0", trc.valid, fifo_count); end
    enable = 1'b1;
    tick(); tick();
    checks++; if (trc.valid !== 1'b1 || trc.data !== {16'd12, 4'd1, 32'd6}) begin errors++; $display("FAIL enable_entry got v=%0b %h exp %h", trc.valid, trc.data, {16'd12, 4'd1, 32'd6}); end
    tick();
    checks++; if (trc.valid !== 1'b0) begin errors++; $display("FAIL enable_end got %0b exp 0", trc.valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_v;
    clear = 1'b1; pc = '0;
    tick();
    clear = 1'b0;
    trc.ready = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      pc = 32'(4 * j);
      tick();
    end
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", fifo_count); end
    checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL ovf_drop got %0d exp 3", drop_count); end
    trc.ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      exp_v = k < 16 ? 32'(4 * (k + 1)) : 32'd80;
      checks++; if (trc.valid !== 1'b1 || src !== 4'd0 || val !== exp_v) begin errors++; $display("FAIL ovf_entry%0d got v=%0b src=%0d val=%0d exp src=0 val=%0d", k, trc.valid, src, val, exp_v); end
      tick();
      if (k == 0) begin
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_pushpop_count got %0d exp 16", fifo_count); end
      end
    end
    checks++; if (trc.valid !== 1'b0 || fifo_count !== 5'd0) begin errors++; $display("FAIL ovf_end got v=%0b cnt=%0d exp 0/0", trc.valid, fifo_count); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_v;
    logic [3:0] exp_s;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    trc.ready = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      pc = 32'(80 + 4 * j);
      tick();
    end
    tick();
    r6 = 32'h77;
    tick();
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", fifo_count); end
    trc.ready = 1'b1;
    tick();
    trc.ready = 1'b0;
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_pushpop_count got %0d exp 16", fifo_count); end
    checks++; if (val !== 32'd88) begin errors++; $display("FAIL full_head got %0d exp 88", val); end
    trc.ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_v = k < 15 ? 32'(88 + 4 * k) : 32'h77;
      exp_s = k < 15 ? TRC_SRC_PC : TRC_SRC_R6;
      checks++; if (trc.valid !== 1'b1 || src !== exp_s || val !== exp_v) begin errors++; $display("FAIL full_entry%0d got v=%0b src=%0d val=%h exp src=%0d val=%h", k, trc.valid, src, val, exp_s, exp_v); end
      tick();
    end
    checks++; if (trc.valid !== 1'b0) begin errors++; $display("FAIL full_end got %0b exp 0", trc.valid); end
  endtask

  task automatic test_clear();
    trc.ready = 1'b0;
    r1 = 32'd3;
    for (int j = 1; j <= 20; j++) begin
      pc = 32'(144 + 4 * j);
      tick();
    end
    checks++; if (drop_count !== 16'd3 || fifo_count !== 5'd16) begin errors++; $display("FAIL clr_pre got drop=%0d cnt=%0d exp 3/16", drop_count, fifo_count); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (fifo_count !== 5'd0 || trc.valid !== 1'b0 || drop_count !== 16'd0) begin errors++; $display("FAIL clr_state got cnt=%0d v=%0b drop=%0d exp 0/0/0", fifo_count, trc.valid, drop_count); end
    trc.ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (trc.valid !== 1'b0 || fifo_count !== 5'd0) begin errors++; $display("FAIL clr_quiet%0d got v=%0b cnt=%0d exp 0/0", k, trc.valid, fifo_count); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] es [7];
    logic [31:0] ev [7];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
    ev = '{32'd224, 32'd6, 32'd3, 32'h22, 32'd9, 32'h55, 32'h77};
    trc.ready = 1'b0;
    r2 = 32'h22; r5 = 32'h55;
    tick(); tick(); tick();
    checks++; if (fifo_count !== 5'd2) begin errors++; $display("FAIL arst_fill got %0d exp 2", fifo_count); end
    trc.ready = 1'b1;
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (trc.valid !== 1'b0 || fifo_count !== 5'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL arst_now got v=%0b cnt=%0d drop=%0d exp 0/0/0", trc.valid, fifo_count, drop_count); end
    tick();
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++; if (trc.valid !== 1'b1 || src !== es[k] || val !== ev[k]) begin errors++; $display("FAIL arst_entry%0d got v=%0b src=%0d val=%h exp src=%0d val=%h", k, trc.valid, src, val, es[k], ev[k]); end
    end
    tick();
    checks++; if (trc.valid !== 1'b0) begin errors++; $display("FAIL arst_end got %0b exp 0", trc.valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_enable();
    test_overflow();
    test_full_pop();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
